ring_meas_ctrl: RTL

//  Measurement sequencer that drives a ring-oscillator edge-counting circuit and reads back its result.
//  - Per request: clears the counter, enables the ring for a fixed window of clk cycles, waits for the count to settle, then captures it.
//  - Presents the count on a valid/ready output; one clock domain (clk), async active-low reset.

---
 rtl/ring_meas_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ring_meas_ctrl.sv
// Ring-oscillator measurement sequencer: clear, open count window, settle, capture, hand off.
// Optional RING_MEAS_AVG_EN averages 2^AVG_LOG2 passes per start (AVG_LOG2 must be >= 1 then).
module ring_meas_ctrl #(
  parameter int unsigned WINDOW   = 100,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned CLR_CYC  = 2,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] count_in,
  output logic        ring_en,
  output logic        cnt_clr,
  output logic [15:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [2:0] {StIdle, StClear, StWindow, StSettle, StHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] result_q, result_d;
  logic        overflow_q, overflow_d;
  logic        ring_en_q, cnt_clr_q, valid_q, busy_q;

`ifdef RING_MEAS_AVG_EN
  localparam int unsigned AccW = 16 + AVG_LOG2;
  logic [AccW-1:0]     acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] pass_q, pass_d;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    result_d   = result_q;
    overflow_d = overflow_q;
`ifdef RING_MEAS_AVG_EN
    acc_d      = acc_q;
    pass_d     = pass_q;
    acc_sum    = acc_q + AccW'(count_in);
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StClear;
          timer_d    = '0;
          overflow_d = 1'b0;
`ifdef RING_MEAS_AVG_EN
          acc_d      = '0;
          pass_d     = '0;
`endif
        end
      end
      StClear: begin
        if (timer_q == 16'(CLR_CYC - 1)) begin
          state_d = StWindow;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StWindow: begin
        if (timer_q == 16'(WINDOW - 1)) begin
          state_d = StSettle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StSettle: begin
        if (timer_q == 16'(SETTLE - 1)) begin
          timer_d = '0;
          if (count_in == 16'hFFFF) overflow_d = 1'b1;
`ifdef RING_MEAS_AVG_EN
          acc_d  = acc_sum;
          pass_d = pass_q + AVG_LOG2'(1);
          // All-ones pass index marks the final pass of the averaging loop.
          if (&pass_q) begin
            state_d  = StHold;
            result_d = acc_sum[AccW-1:AVG_LOG2];
          end else begin
            state_d = StClear;
          end
`else
          state_d  = StHold;
          result_d = count_in;
`endif
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StHold: begin
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      ring_en_q  <= 1'b0;
      cnt_clr_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      ring_en_q  <= (state_d == StWindow);
      cnt_clr_q  <= (state_d == StClear);
      valid_q    <= (state_d == StHold);
      busy_q     <= (state_d != StIdle);
    end
  end

`ifdef RING_MEAS_AVG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      pass_q <= '0;
    end else begin
      acc_q  <= acc_d;
      pass_q <= pass_d;
    end
  end
`endif

  assign ring_en      = ring_en_q;
  assign cnt_clr      = cnt_clr_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule
